// File: rtl/daq_pkg.sv
// daq_pkg: shared definitions for the daq arbiter.
//   state_t      : arbiter FSM encoding (IDLE = 0, BUSY = 1, GAP = 2)
//   SRC_MSB/LSB  : position of the source index inside the timestamp header
//   make_header  : builds {src, systime[27:0]} header word
package daq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int SRC_MSB = 31;
  localparam int SRC_LSB = 28;

  function automatic logic [31:0] make_header(input logic [3:0] src, input logic [31:0] t);
    logic [31:0] h;
    h = '0;
    h[SRC_MSB:SRC_LSB]   = src;
    h[SRC_LSB-1:0]       = t[SRC_LSB-1:0];
    return h;
  endfunction

endpackage

// File: rtl/daq_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority search.
//   req   [N-1:0] : request vector
//   ptr   [W-1:0] : index searched first; search wraps modulo N
//   idx   [W-1:0] : first requesting index at or after ptr
//   found         : at least one request is pending
module rr_pick #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  int         c_int;
  logic [W-1:0] c;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    c_int = 0;
    c     = '0;
    for (int i = 0; i < N; i++) begin
      c_int = int'(ptr) + i;
      if (c_int >= N) c_int = c_int - N;
      c = W'(c_int);
      if (!found && req[c]) begin
        idx   = c;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/daq_arbiter.sv
// daq_arbiter: round-robin scheduler sharing the packetiser input among NDAQ
// acquisition sources. Grants are bounded by a word budget and an idle timeout,
// and only issued when the downstream buffer can absorb a worst-case burst.
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   systime[31:0]         : free-running time (used for the optional header)
//   daq_data_in[32*NDAQ]  : flattened source words, source i at [32i+31:32i]
//   daq_valid/end/req     : per-source strobes and level request
//   daq_grant[NDAQ]       : registered one-hot grant
//   fifo_space            : free words downstream
//   out_data/valid/end    : registered muxed output stream
//   out_src               : index of the granted source
//   err_timeout/err_burst : sticky error flags
//
// Build option: define DAQ_ARB_TSTAMP_EN to prepend a {src, systime[27:0]}
// header to every grant. Words then flow through a 1-word skid register.
//
// state | meaning
// IDLE  | arbitrate when space allows; grant the round-robin winner
// BUSY  | forward the granted source until end, budget or timeout
// GAP   | one cycle with grant low; late words flag err_burst
module daq_arbiter
  import daq_pkg::*;
#(
  parameter int NDAQ       = 5,
  parameter int MAX_BURST  = 64,
  parameter int TIMEOUT    = 1024,
  parameter int SPACE_BITS = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             systime,
  input  logic [32*NDAQ-1:0]      daq_data_in,
  input  logic [NDAQ-1:0]         daq_valid,
  input  logic [NDAQ-1:0]         daq_end,
  input  logic [NDAQ-1:0]         daq_req,
  output logic [NDAQ-1:0]         daq_grant,
  input  logic [SPACE_BITS-1:0]   fifo_space,
  output logic [31:0]             out_data,
  output logic                    out_valid,
  output logic                    out_end,
  output logic [$clog2(NDAQ)-1:0] out_src,
  output logic                    err_timeout,
  output logic                    err_burst
);

  localparam int SRC_W  = $clog2(NDAQ);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam int ICNT_W = $clog2(TIMEOUT);
`ifdef DAQ_ARB_TSTAMP_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  state_t              state, state_nxt;
  logic [SRC_W-1:0]    ptr, ptr_nxt;
  logic [NDAQ-1:0]     grant_nxt;
  logic [SRC_W-1:0]    src_nxt;
  logic [BCNT_W-1:0]   bcnt, bcnt_nxt;
  logic [ICNT_W-1:0]   icnt, icnt_nxt;
  logic                err_t_nxt, err_b_nxt;
  logic                grant_fire;
  logic                budget_hit, timeout_hit;
  logic                stg_valid, stg_end;
  logic [31:0]         stg_data;

  logic [SRC_W-1:0]    pick_idx;
  logic                pick_found;
  logic                space_ok;
  logic                src_valid, src_end;
  logic [31:0]         src_data [NDAQ];

  always_comb begin
    for (int i = 0; i < NDAQ; i++) src_data[i] = daq_data_in[32*i +: 32];
  end

  assign src_valid = daq_valid[out_src];
  assign src_end   = daq_end[out_src];
  assign space_ok  = int'(fifo_space) >= MAX_BURST + HDR_WORDS;

  rr_pick #(.N(NDAQ), .W(SRC_W)) u_pick (
    .req   (daq_req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    grant_nxt   = daq_grant;
    src_nxt     = out_src;
    bcnt_nxt    = bcnt;
    icnt_nxt    = icnt;
    err_t_nxt   = err_timeout;
    err_b_nxt   = err_burst;
    grant_fire  = 1'b0;
    budget_hit  = 1'b0;
    timeout_hit = 1'b0;
    stg_valid   = 1'b0;
    stg_end     = 1'b0;
    stg_data    = '0;

    case (state)
      IDLE: begin
        if (space_ok && pick_found) begin
          grant_fire          = 1'b1;
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          src_nxt             = pick_idx;
          ptr_nxt             = (pick_idx == SRC_W'(NDAQ - 1)) ? '0 : pick_idx + 1'b1;
          bcnt_nxt            = '0;
          icnt_nxt            = '0;
          state_nxt           = BUSY;
        end
      end

      BUSY: begin
        if (src_valid) begin
          stg_valid = 1'b1;
          stg_data  = src_data[out_src];
          if (bcnt != BCNT_W'(MAX_BURST)) bcnt_nxt = bcnt + 1'b1;
          budget_hit = (bcnt == BCNT_W'(MAX_BURST - 1));
        end
        // Activity clears the idle counter, so end always beats timeout.
        if (src_valid || src_end)               icnt_nxt    = '0;
        else if (icnt == ICNT_W'(TIMEOUT - 1))  timeout_hit = 1'b1;
        else                                    icnt_nxt    = icnt + 1'b1;

        if (src_end || budget_hit || timeout_hit) begin
          stg_end   = 1'b1;
          grant_nxt = '0;
          state_nxt = GAP;
        end
        if (timeout_hit) err_t_nxt = 1'b1;
      end

      GAP: begin
        // The counter still holds MAX_BURST only if the budget ran out.
        if (src_valid && bcnt == BCNT_W'(MAX_BURST)) err_b_nxt = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      daq_grant   <= '0;
      out_src     <= '0;
      bcnt        <= '0;
      icnt        <= '0;
      err_timeout <= 1'b0;
      err_burst   <= 1'b0;
    end else begin
      ptr         <= ptr_nxt;
      daq_grant   <= grant_nxt;
      out_src     <= src_nxt;
      bcnt        <= bcnt_nxt;
      icnt        <= icnt_nxt;
      err_timeout <= err_t_nxt;
      err_burst   <= err_b_nxt;
    end
  end

`ifdef DAQ_ARB_TSTAMP_EN
  logic        hdr_pend;
  logic [31:0] hdr_q;
  logic        skid_valid, skid_end;
  logic [31:0] skid_data;
  logic        unused_systime;

  assign unused_systime = ^systime[31:SRC_LSB];

  // Header goes out in the first BUSY cycle; every source word is delayed
  // one cycle by the skid so it never collides with the header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_pend   <= 1'b0;
      hdr_q      <= '0;
      skid_valid <= 1'b0;
      skid_end   <= 1'b0;
      skid_data  <= '0;
      out_valid  <= 1'b0;
      out_end    <= 1'b0;
      out_data   <= '0;
    end else begin
      hdr_pend   <= grant_fire;
      if (grant_fire) hdr_q <= make_header(4'(pick_idx), systime);
      skid_valid <= stg_valid;
      skid_end   <= stg_end;
      skid_data  <= stg_data;
      if (hdr_pend) begin
        out_valid <= 1'b1;
        out_end   <= 1'b0;
        out_data  <= hdr_q;
      end else begin
        out_valid <= skid_valid;
        out_end   <= skid_end;
        out_data  <= skid_data;
      end
    end
  end
`else
  logic unused_systime;
  logic unused_fire;

  assign unused_systime = ^systime;
  assign unused_fire    = grant_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_end   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= stg_valid;
      out_end   <= stg_end;
      out_data  <= stg_data;
    end
  end
`endif

endmodule

// File: tb/tb_daq_arbiter.sv
// tb_daq_arbiter: directed bench with an output scoreboard for daq_arbiter.
module tb_daq_arbiter;

  localparam int NDAQ       = 5;
  localparam int MAX_BURST  = 64;
  localparam int TIMEOUT    = 1024;
  localparam int SPACE_BITS = 9;
  localparam int SRC_W      = 3;
`ifdef DAQ_ARB_TSTAMP_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif
  localparam int TH = MAX_BURST + H;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [31:0]           st_cnt = '0;
  logic [31:0]           st_hold = '0;
  logic                  st_run = 1'b1;
  wire  [31:0]           systime;
  logic [32*NDAQ-1:0]    daq_data_in;
  logic [NDAQ-1:0]       daq_valid, daq_end, daq_req, daq_grant;
  logic [SPACE_BITS-1:0] fifo_space;
  logic [31:0]           out_data;
  logic                  out_valid, out_end;
  logic [SRC_W-1:0]      out_src;
  logic                  err_timeout, err_burst;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t e;

  assign systime = st_run ? st_cnt : st_hold;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) st_cnt <= st_cnt + 1;

  daq_arbiter #(
    .NDAQ(NDAQ), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT), .SPACE_BITS(SPACE_BITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .systime     (systime),
    .daq_data_in (daq_data_in),
    .daq_valid   (daq_valid),
    .daq_end     (daq_end),
    .daq_req     (daq_req),
    .daq_grant   (daq_grant),
    .fifo_space  (fifo_space),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_end     (out_end),
    .out_src     (out_src),
    .err_timeout (err_timeout),
    .err_burst   (err_burst)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive(input int idx, input logic v, input logic en, input logic [31:0] d);
    daq_valid[idx] = v;
    daq_end[idx]   = en;
    daq_data_in[32*idx +: 32] = d;
  endtask

  task automatic push(input logic v, input logic en, input logic [31:0] d);
    exp_t x;
    x.v = v; x.e = en; x.d = d;
    exp_q.push_back(x);
  endtask

  // Expected header for a grant seen now: systime only changes on negedge,
  // so the current value is the one present at the grant edge.
  task automatic push_hdr(input int idx);
    if (H != 0) push(1'b1, 1'b0, {4'(idx), systime[27:0]});
  endtask

  task automatic wait_grant(input int idx, output int t);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (daq_grant == '0 && k < 40);
    t = cyc;
    check("grant", 64'(daq_grant), 64'(1) << idx);
    check("out_src", 64'(out_src), 64'(idx));
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    daq_req   = '0;
    daq_valid = '0;
    daq_end   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_tests();
    int t, tprev, idx, k;
    logic any_grant;

    daq_data_in = '0;
    fifo_space  = '0;
    apply_reset();

    // reset state
    check("rst_grant", 64'(daq_grant), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_end", 64'(out_end), 0);
    check("rst_out_src", 64'(out_src), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_err_timeout", 64'(err_timeout), 0);
    check("rst_err_burst", 64'(err_burst), 0);

    // alternation between requesters 0 and 3
    fifo_space = 9'd100;
    daq_req    = 5'b01001;
    tprev = 0;
    for (int n = 0; n < 3; n++) begin
      idx = (n % 2 == 0) ? 0 : 3;
      wait_grant(idx, t);
      push_hdr(idx);
      drive(idx, 1'b1, 1'b1, 32'hA000_0000 + 32'(n));
      push(1'b1, 1'b1, 32'hA000_0000 + 32'(n));
      @(posedge clk); #1;
      drive(idx, 1'b0, 1'b0, '0);
      check("release", 64'(daq_grant), 0);
      if (n > 0) check("grant_spacing", 64'(t - tprev), 3);
      tprev = t;
    end
    daq_req = '0;

    // budget: source 2 sends 70 words, no end (ptr is now 1)
    daq_req = 5'b00100;
    wait_grant(2, t);
    push_hdr(2);
    for (int n = 1; n <= 70; n++) begin
      drive(2, 1'b1, 1'b0, 32'h0200_0000 + 32'(n));
      if (n <= 64) push(1'b1, n == 64, 32'h0200_0000 + 32'(n));
      if (n == 60) daq_req = '0;
      if (n == 65) check("err_burst_before", 64'(err_burst), 0);
      @(posedge clk); #1;
    end
    drive(2, 1'b0, 1'b0, '0);
    check("err_burst_after", 64'(err_burst), 1);
    check("no_regrant", 64'(daq_grant), 0);
    check("err_timeout_clean", 64'(err_timeout), 0);

    // timeout: source 1 granted, silent (ptr is now 3)
    daq_req = 5'b00010;
    wait_grant(1, t);
    push_hdr(1);
    daq_req = '0;
    push(1'b0, 1'b1, '0);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!out_end && k < TIMEOUT + 20);
    check("timeout_latency", 64'(cyc - t), 64'(TIMEOUT + H));
    check("timeout_valid_low", 64'(out_valid), 0);
    check("err_timeout_set", 64'(err_timeout), 1);
    check("timeout_release", 64'(daq_grant), 0);
    repeat (3) @(posedge clk);
    #1;

    // space threshold, then a valid+end on word 64
    apply_reset();
    check("rst_err_cleared", 64'({err_timeout, err_burst}), 0);
    fifo_space = 9'(TH - 1);
    daq_req    = 5'b00001;
    any_grant  = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (daq_grant != '0) any_grant = 1'b1;
    end
    check("no_grant_low_space", 64'(any_grant), 0);
    fifo_space = 9'(TH);
    @(posedge clk); #1;
    check("grant_on_space", 64'(daq_grant), 1);
    push_hdr(0);
    for (int n = 1; n <= 64; n++) begin
      drive(0, 1'b1, n == 64, 32'h5000_0000 + 32'(n));
      push(1'b1, n == 64, 32'h5000_0000 + 32'(n));
      if (n == 64) daq_req = '0;
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, '0);
    check("end64_release", 64'(daq_grant), 0);
    repeat (3) @(posedge clk);
    #1;
    check("end64_err_burst", 64'(err_burst), 0);
    check("end64_err_timeout", 64'(err_timeout), 0);

`ifdef DAQ_ARB_TSTAMP_EN
    // header on a grant to source 4 at systime 0x0ABCDEF0
    apply_reset();
    st_hold    = 32'h0ABC_DEF0;
    st_run     = 1'b0;
    fifo_space = 9'd65;
    daq_req    = 5'b10000;
    wait_grant(4, t);
    push(1'b1, 1'b0, 32'h4ABC_DEF0);
    drive(4, 1'b1, 1'b1, 32'h4444_0001);
    push(1'b1, 1'b1, 32'h4444_0001);
    @(posedge clk); #1;
    drive(4, 1'b0, 1'b0, '0);
    daq_req = '0;
    st_run  = 1'b1;
`endif

    repeat (10) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    daq_req     = '0;
    daq_valid   = '0;
    daq_end     = '0;
    daq_data_in = '0;
    fifo_space  = '0;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst_n && (out_valid || out_end)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL out_unexpected: got v=%0b e=%0b d=%08h, required no output",
                       out_valid, out_end, out_data);
            end else begin
              e = exp_q.pop_front();
              if (out_valid !== e.v || out_end !== e.e || (e.v && out_data !== e.d)) begin
                n_err++;
                $display("FAIL out_word: got v=%0b e=%0b d=%08h, required v=%0b e=%0b d=%08h",
                         out_valid, out_end, out_data, e.v, e.e, e.d);
              end
            end
          end
        end
      end
      begin : watchdog
        #500000;
        n_err++;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
      end
      begin : main
        run_tests();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/daq_arbiter.md
# daq_arbiter

Round-robin scheduler that shares the single daq packetiser input among NDAQ acquisition sources. It answers per-source `daq_req` with one-hot `daq_grant` and muxes the granted source's 32-bit words onto one output stream. It bounds every grant by a word budget and an idle timeout. A grant is issued only when the downstream packet buffer has room for a worst-case burst, so no word is ever dropped. It sits between the sampling units and the daq/mac packet path.

## Interface
- `NDAQ`, 5: number of requesters; must be 2..16.
- `MAX_BURST`, 64: maximum data words per grant; must be 1..255.
- `TIMEOUT`, 1024: cycles without `daq_valid` or `daq_end` before a grant is revoked; must be ≥ 2.
- `SPACE_BITS`, 9: width of `fifo_space`.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `systime`  in  32  free-running system time.
- `daq_data_in`  in  32*NDAQ  flattened source data; source i occupies bits [32i+31:32i].
- `daq_valid`  in  NDAQ  per-source data-valid.
- `daq_end`  in  NDAQ  per-source end of burst; may coincide with `daq_valid`.
- `daq_req`  in  NDAQ  per-source request, level.
- `daq_grant`  out  NDAQ  one-hot grant, registered.
- `fifo_space`  in  SPACE_BITS  free words downstream.
- `out_data`  out  32  muxed word.
- `out_valid`  out  1  word strobe.
- `out_end`  out  1  burst terminator; may be high with `out_valid` low.
- `out_src`  out  $clog2(NDAQ)  index of the granted source.
- `err_timeout`  out  1  sticky; set by any timeout revoke.
- `err_burst`  out  1  sticky; set when a source asserts `daq_valid` after its budget is exhausted.

## Operation
- There are three states: IDLE, BUSY and GAP. Reset enters IDLE. Reset drives every output to 0, clears both error flags, clears the counters and sets the round-robin pointer to 0.
- **IDLE.** Arbitration runs when `fifo_space` ≥ MAX_BURST + H, where H = 1 if `DAQ_ARB_TSTAMP_EN` is defined and H = 0 otherwise.
  - Requesters are searched starting at pointer `ptr` and wrapping modulo NDAQ.
  - The first index w with `daq_req[w]` high wins. The block registers `daq_grant = 1<<w` and `out_src = w`, sets `ptr = (w+1) mod NDAQ` and enters BUSY.
  - If no request is pending, or space is insufficient, the block stays in IDLE and `ptr` is unchanged.
- **BUSY.** Only the granted source is observed; all other sources' inputs are ignored.
  - `daq_valid[w]` produces `out_valid = 1` with `out_data = daq_data_in[w]` and increments the burst count.
  - `daq_end[w]` produces `out_end = 1`, drops the grant and enters GAP.
  - Budget revoke: when the burst count reaches MAX_BURST, that last word carries `out_end = 1`, the grant drops and the state goes to GAP.
  - Any later `daq_valid[w]` while in GAP sets `err_burst`; the word is not forwarded.
  - Timeout revoke: the idle counter counts BUSY cycles with neither `daq_valid[w]` nor `daq_end[w]`, and clears on either. When it reaches TIMEOUT−1, the block emits `out_end = 1` with `out_valid = 0`, sets `err_timeout`, drops the grant and enters GAP.
- **GAP.** Lasts exactly 1 cycle with the grant low, then the block returns to IDLE. A source that still requests therefore loses no more than one arbitration round.
- Simultaneous termination events are merged into a single `out_end`:
  - end and budget together count as a normal end;
  - valid + end on the 64th word counts as one end;
  - timeout and end in the same cycle: end wins and `err_timeout` is not set.
- If `daq_req[w]` drops mid-burst, nothing happens; only end, budget or timeout release the grant.

## Timing
- Grant latency: request sampled in IDLE → `daq_grant` high the next cycle.
- Data path latency: `daq_valid` in cycle n → `out_valid` in cycle n+1. `out_*` are registered and the mux is a single stage.
- Release: the grant is low in the cycle after `out_end`.
- Minimum spacing between consecutive grants: 3 cycles (BUSY end cycle, GAP, IDLE decision).
- `fifo_space` is sampled only in IDLE. The guarantee is that space stays ≥ MAX_BURST + H for the whole burst, since no other writer exists.
- The burst counter is $clog2(MAX_BURST+1) bits and saturates; it is cleared on grant.

## Configuration
- `DAQ_ARB_TSTAMP_EN`
  - **Defined:** in the first BUSY cycle, the block emits one header word with `out_valid = 1`: {`out_src` in [31:28], `systime[27:0]`}. `systime` is sampled on the grant edge. The header does not count against MAX_BURST. A source word arriving in that same cycle is held in a 1-word skid register and forwarded next cycle; any following words keep the 1-cycle offset. The space check uses H = 1.
  - **Undefined:** there is no header, no skid register, and H = 0.

## Structure
- Package `daq_pkg` holds the state encoding (IDLE = 0, BUSY = 1, GAP = 2) and the header field positions (SRC_MSB = 31, SRC_LSB = 28).
- One sub-module, `rr_pick`: combinational round-robin priority search returning the winner index and a found flag, with inputs `req` and `ptr`.

## Test plan
- Requesters 0 and 3 high, `ptr` = 0, space 100. Expect grant 0, then 3, then 0: strict alternation with a 3-cycle gap.
- Source 2 sends 70 valid words with no end. Expect 64 words out, `out_end` on word 64, then `err_burst` set when word 65 arrives.
- Source 1 granted, sends nothing. Expect `out_end` alone at cycle TIMEOUT after the grant, and `err_timeout` = 1.
- `fifo_space` = 63 with a request pending (H = 0). Expect no grant; raising space to 64 gives a grant the next cycle.
- Word 64 sent with valid + end together. Expect a single `out_end`, no error, and the grant low in the next cycle.
- With `DAQ_ARB_TSTAMP_EN`: grant at `systime` = 0x0ABCDEF0 to source 4, with data in the first grant cycle. Expect header 0x4ABCDEF0 followed by the data word, and `fifo_space` threshold 65.
